// File: rtl/ldpc_cw_pkg.sv
// Shared register map, STATUS layout and FSM states for the LDPC codeword stager.
package ldpc_cw_pkg;

    localparam logic [11:0] OFS_CTRL    = 12'h000;
    localparam logic [11:0] OFS_STATUS  = 12'h004;
    localparam logic [3:0]  PAGE_CW_IN  = 4'h1;
    localparam logic [3:0]  PAGE_CW_OUT = 4'h2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_SYN   = 2;
    localparam int ST_PEND  = 3;
    localparam int ST_OVR   = 4;
    localparam int ST_FBANK = 5;
    localparam int ST_SPUR  = 6;
    localparam int ST_IRQEN = 7;
    localparam int ST_ITER  = 8;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_RES
    } cw_state_e;

    function automatic int cw_nw(input int nn);
        return (nn + 31) / 32;
    endfunction

endpackage

// File: rtl/ldpc_cw_bank.sv
// One NN-bit codeword bank: byte-masked 32-bit word write, single-bit write, word read.
module ldpc_cw_bank
    import ldpc_cw_pkg::*;
#(
    parameter int NN = 208
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [15:0]   i_wr_idx,
    input  logic [31:0]   i_wr_data,
    input  logic [3:0]    i_wr_sel,
    input  logic          i_bit_we,
    input  logic [15:0]   i_bit_idx,
    input  logic          i_bit_val,
    input  logic [15:0]   i_rd_idx,
    output logic [31:0]   o_rd_data,
    output logic [NN-1:0] o_data
);

    localparam int NW = cw_nw(NN);
    localparam int W  = NW * 32;
    // Bits at or above NN are never written, so the pad of the last word reads 0.
    localparam logic [W-1:0] NN_MASK = {W{1'b1}} >> (W - NN);

    logic [W-1:0] r_mem;
    logic [W-1:0] w_word_mask;
    logic [W-1:0] w_word_val;
    logic [W-1:0] w_bit_mask;
    logic [W-1:0] w_merged;
    logic [W-1:0] w_next;
    logic [W-1:0] w_rd_sh;
    logic [31:0]  w_byte_mask;
    logic [20:0]  w_wr_sh;

    always_comb begin
        w_byte_mask = {{8{i_wr_sel[3]}}, {8{i_wr_sel[2]}}, {8{i_wr_sel[1]}}, {8{i_wr_sel[0]}}};
        w_wr_sh     = {i_wr_idx, 5'd0};
        w_word_mask = i_wr_en ? ((W'(w_byte_mask) << w_wr_sh) & NN_MASK) : '0;
        w_word_val  = W'(i_wr_data) << w_wr_sh;
        w_bit_mask  = i_bit_we ? ((W'(1) << i_bit_idx) & NN_MASK) : '0;
        // Serial bit is merged after the word write so it wins on overlap.
        w_merged    = (r_mem & ~w_word_mask) | (w_word_val & w_word_mask);
        w_next      = (w_merged & ~w_bit_mask) | (i_bit_val ? w_bit_mask : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '0;
        end else begin
            r_mem <= w_next;
        end
    end

    assign w_rd_sh   = r_mem >> {i_rd_idx, 5'd0};
    assign o_rd_data = w_rd_sh[31:0];
    assign o_data    = r_mem[NN-1:0];

endmodule

// File: rtl/ldpc_cw_stager.sv
// Wishbone-attached ping-pong codeword staging between host, serial bit port and LDPC core.
module ldpc_cw_stager
    import ldpc_cw_pkg::*;
#(
    parameter int          NN       = 208,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          ITER_W   = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              P_input,
    input  logic              P_input_we,
    input  logic [15:0]       P_input_sel,
    output logic              PO_output,
    input  logic [15:0]       PO_output_sel,
    output logic              cw_valid_o,
    input  logic              cw_ready_i,
    output logic [NN-1:0]     cw_data_o,
    input  logic              res_valid_i,
    input  logic [NN-1:0]     res_data_i,
    input  logic              res_syn_ok_i,
    input  logic [ITER_W-1:0] res_iter_i,
    output logic [2:0]        irq
);

    localparam int NW = cw_nw(NN);
    localparam int W  = NW * 32;

    cw_state_e         r_state;
    cw_state_e         w_state_nxt;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_fill_bank;
    logic              r_pend;
    logic              r_ovr;
    logic              r_done;
    logic              r_syn;
    logic              r_spur;
    logic              r_irq_en;
    logic              r_po;
    logic [ITER_W-1:0] r_iter;
    logic [NN-1:0]     r_res;

    logic              w_hit;
    logic              w_wr;
    logic [11:0]       w_ofs;
    logic [15:0]       w_widx;
    logic              w_in_rng;
    logic              w_sel_in;
    logic              w_sel_out;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_clr;
    logic              w_cap;
    logic              w_busy;
    logic              w_swap;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;
    logic [W-1:0]      w_res_sh;
    logic [NN-1:0]     w_po_sh;
    logic              w_unused;

    logic [1:0][31:0]    w_bank_rd;
    logic [1:0][NN-1:0]  w_bank_data;

    assign w_hit     = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    assign w_wr      = w_hit & wbs_we_i;
    assign w_ofs     = wbs_adr_i[11:0];
    assign w_widx    = {10'd0, w_ofs[7:2]};
    assign w_in_rng  = (w_widx < 16'(NW));
    assign w_sel_in  = (w_ofs[11:8] == PAGE_CW_IN) & w_in_rng;
    assign w_sel_out = (w_ofs[11:8] == PAGE_CW_OUT) & w_in_rng;
    assign w_ctrl_wr = w_wr & (w_ofs == OFS_CTRL) & wbs_sel_i[0];
    assign w_start   = w_ctrl_wr & wbs_dat_i[CTRL_START];
    assign w_clr     = w_ctrl_wr & wbs_dat_i[CTRL_CLR];
    assign w_busy    = (r_state != IDLE);
    assign w_cap     = (r_state == WAIT_RES) & res_valid_i;
    assign w_unused  = ^wbs_adr_i[1:0];

    // Host and serial writes always land in the fill bank; the core sees the other one.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        ldpc_cw_bank #(.NN(NN)) u_bank (
            .i_clk     (wb_clk_i),
            .i_rst     (wb_rst_i),
            .i_wr_en   (w_wr & w_sel_in & (r_fill_bank == 1'(b))),
            .i_wr_idx  (w_widx),
            .i_wr_data (wbs_dat_i),
            .i_wr_sel  (wbs_sel_i),
            .i_bit_we  (P_input_we & (r_fill_bank == 1'(b))),
            .i_bit_idx (P_input_sel),
            .i_bit_val (P_input),
            .i_rd_idx  (w_widx),
            .o_rd_data (w_bank_rd[b]),
            .o_data    (w_bank_data[b])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = OFFER;
                    w_swap      = 1'b1;
                end
            end
            OFFER: begin
                if (cw_ready_i) w_state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                // A START landing with the result is treated as already queued.
                if (res_valid_i) begin
                    if (r_pend | w_start) begin
                        w_state_nxt = OFFER;
                        w_swap      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_status                     = '0;
        w_status[ST_BUSY]            = w_busy;
        w_status[ST_DONE]            = r_done;
        w_status[ST_SYN]             = r_syn;
        w_status[ST_PEND]            = r_pend;
        w_status[ST_OVR]             = r_ovr;
        w_status[ST_FBANK]           = r_fill_bank;
        w_status[ST_SPUR]            = r_spur;
        w_status[ST_IRQEN]           = r_irq_en;
        w_status[ST_ITER +: ITER_W]  = r_iter;
    end

    assign w_res_sh = W'(r_res) >> {w_widx, 5'd0};

    always_comb begin
        w_rdata = '0;
        if (w_ofs == OFS_CTRL)        w_rdata[CTRL_IRQ_EN] = r_irq_en;
        else if (w_ofs == OFS_STATUS) w_rdata = w_status;
        else if (w_sel_in)            w_rdata = w_bank_rd[r_fill_bank];
        else if (w_sel_out)           w_rdata = w_res_sh[31:0];
    end

    // Shifting past NN yields 0, which covers out-of-range result selects.
    assign w_po_sh = r_res >> PO_output_sel;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_fill_bank <= 1'b0;
            r_pend      <= 1'b0;
            r_ovr       <= 1'b0;
            r_done      <= 1'b0;
            r_syn       <= 1'b0;
            r_spur      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_po        <= 1'b0;
            r_iter      <= '0;
            r_res       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_hit;
            r_dat   <= (w_hit & ~wbs_we_i) ? w_rdata : '0;
            r_po    <= w_po_sh[0];
            if (w_swap)    r_fill_bank <= ~r_fill_bank;
            if (w_ctrl_wr) r_irq_en    <= wbs_dat_i[CTRL_IRQ_EN];
            if (w_clr) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_cap) begin
                r_pend <= r_pend & w_start;
            end else if (w_busy & w_start) begin
                if (r_pend) r_ovr  <= 1'b1;
                else        r_pend <= 1'b1;
            end
            if (w_cap) begin
                r_res  <= res_data_i;
                r_syn  <= res_syn_ok_i;
                r_iter <= res_iter_i;
                r_done <= 1'b1;
            end
            if (res_valid_i & (r_state != WAIT_RES)) r_spur <= 1'b1;
        end
    end

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign PO_output  = r_po;
    assign cw_valid_o = (r_state == OFFER);
    assign cw_data_o  = cw_valid_o ? w_bank_data[~r_fill_bank] : '0;
    assign irq        = {2'b00, r_done & r_irq_en};

endmodule

// File: tb/tb_ldpc_cw_stager.sv
// Directed bench for ldpc_cw_stager: bus decode, ping-pong offer, queue/overrun, serial port.
module tb_ldpc_cw_stager;

    localparam int          NN   = 208;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h000;
    localparam logic [31:0] A_STAT = BASE + 32'h004;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_w;
    logic              ack;
    logic [31:0]       dat_r;
    logic              p_in, p_we;
    logic [15:0]       p_sel;
    logic              po;
    logic [15:0]       po_sel;
    logic              cw_valid, cw_ready;
    logic [NN-1:0]     cw_data;
    logic              res_valid;
    logic [NN-1:0]     res_data;
    logic              res_syn;
    logic [7:0]        res_iter;
    logic [2:0]        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ldpc_cw_stager #(.NN(NN), .BASE_ADR(BASE), .ITER_W(8)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat_w),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_r),
        .P_input       (p_in),
        .P_input_we    (p_we),
        .P_input_sel   (p_sel),
        .PO_output     (po),
        .PO_output_sel (po_sel),
        .cw_valid_o    (cw_valid),
        .cw_ready_i    (cw_ready),
        .cw_data_o     (cw_data),
        .res_valid_i   (res_valid),
        .res_data_i    (res_data),
        .res_syn_ok_i  (res_syn),
        .res_iter_i    (res_iter),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cw_in(input int k);
        return BASE + 32'h100 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] cw_out(input int k);
        return BASE + 32'h200 + 32'(4 * k);
    endfunction

    // One Wishbone access; an optional serial bit write rides on the same edge as the bus hit.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic bwe, input logic [15:0] bsel,
                           input logic bval, output logic [31:0] rd, output logic acked);
        acked = 1'b0;
        rd    = '0;
        @(negedge clk);
        for (int i = 0; i < 4 && ack; i++) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        p_we = bwe; p_sel = bsel; p_in = bval;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            p_we = 1'b0;
            if (ack) begin
                acked = 1'b1;
                rd    = dat_r;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(a, 1'b1, d, s, 1'b0, 16'd0, 1'b0, rd, acked);
        check({tag, "_ack"}, 256'(acked), 256'(1));
    endtask

    task automatic wb_wr_bit(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [15:0] bsel, input logic bval);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(a, 1'b1, d, 4'hF, 1'b1, bsel, bval, rd, acked);
        check({tag, "_ack"}, 256'(acked), 256'(1));
    endtask

    task automatic wb_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, 1'b0, 16'd0, 1'b0, rd, acked);
        check({tag, "_ack"}, 256'(acked), 256'(1));
        check(tag, 256'(rd), 256'(exp));
    endtask

    task automatic ser_bit(input logic [15:0] bsel, input logic bval);
        @(negedge clk);
        p_we = 1'b1; p_sel = bsel; p_in = bval;
        @(negedge clk);
        p_we = 1'b0;
    endtask

    // Core model: wait for the offer, hold off 3 cycles, accept, return a result next cycle.
    task automatic core_run(input string tag, input logic [NN-1:0] exp_cw,
                            input logic [NN-1:0] res, input logic syn, input logic [7:0] it);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cw_valid;
        end
        check({tag, "_offer"}, 256'(got), 256'(1));
        check({tag, "_cw_at_offer"}, 256'(cw_data), 256'(exp_cw));
        repeat (3) @(negedge clk);
        check({tag, "_cw_held"}, 256'(cw_data), 256'(exp_cw));
        cw_ready = 1'b1;
        @(negedge clk);
        cw_ready  = 1'b0;
        res_valid = 1'b1; res_data = res; res_syn = syn; res_iter = it;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [223:0]  tmp;
        logic [NN-1:0] exp_cw;
        logic [31:0]   rd;
        logic          acked;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        p_in = 1'b0; p_we = 1'b0; p_sel = '0; po_sel = '0;
        cw_ready = 1'b0; res_valid = 1'b0; res_data = '0; res_syn = 1'b0; res_iter = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_cw_valid", 256'(cw_valid), 256'(0));
        check("rst_irq", 256'(irq), 256'(0));
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_po", 256'(po), 256'(0));
        wb_rd_chk("rst_status", A_STAT, 32'h0);

        // Bus edges: pad bytes of the last word, unmapped offset, foreign base
        wb_wr("w6_hi", cw_in(6), 32'hFFFF_FFFF, 4'b1100);
        wb_rd_chk("w6_hi_rd", cw_in(6), 32'h0);
        wb_wr("w6_lo", cw_in(6), 32'hFFFF_FFFF, 4'b0011);
        wb_rd_chk("w6_lo_rd", cw_in(6), 32'h0000_FFFF);
        wb_rd_chk("ofs300", BASE + 32'h300, 32'h0);
        wb_xfer(32'h4000_0004, 1'b0, 32'd0, 4'hF, 1'b0, 16'd0, 1'b0, rd, acked);
        check("foreign_noack", 256'(acked), 256'(0));

        // Reset while offering
        wb_wr("start_pre_rst", A_CTRL, 32'h3, 4'hF);
        @(negedge clk);
        check("offer_pre_rst", 256'(cw_valid), 256'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", 256'(cw_valid), 256'(0));
        check("rst_mid_irq", 256'(irq), 256'(0));
        wb_rd_chk("rst_mid_status", A_STAT, 32'h0);
        @(negedge clk);
        res_valid = 1'b1; res_data = '1;
        @(negedge clk);
        res_valid = 1'b0;
        wb_rd_chk("late_res_status", A_STAT, 32'h40);
        wb_rd_chk("late_res_out0", cw_out(0), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic run through bank 0
        for (int k = 0; k < 7; k++) begin
            wb_wr("cw_in", cw_in(k), 32'hA5A5_0000 + 32'(k), 4'hF);
            tmp[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
        end
        tmp[223:208] = 16'h0;
        exp_cw = tmp[NN-1:0];
        wb_wr("start1", A_CTRL, 32'h3, 4'hF);
        core_run("run1", exp_cw, ~exp_cw, 1'b1, 8'd4);
        check("run1_idle", 256'(cw_valid), 256'(0));
        wb_rd_chk("run1_status", A_STAT, 32'h0000_04A6);
        check("run1_irq", 256'(irq), 256'(1));
        wb_rd_chk("run1_out6", cw_out(6), 32'h0000_FFF9);
        wb_rd_chk("run1_out0", cw_out(0), 32'h5A5A_FFFF);
        wb_rd_chk("run1_fill_swapped", cw_in(0), 32'h0);

        // Result bit port
        @(negedge clk); po_sel = 16'd5;
        @(negedge clk); check("po_bit5", 256'(po), 256'(1));
        po_sel = 16'd16;
        @(negedge clk); check("po_bit16", 256'(po), 256'(0));
        po_sel = 16'd207;
        @(negedge clk); check("po_bit207", 256'(po), 256'(1));
        po_sel = 16'd208;
        @(negedge clk); check("po_bit208", 256'(po), 256'(0));

        // Queue and overrun
        wb_wr("clr1", A_CTRL, 32'h6, 4'hF);
        wb_rd_chk("clr1_status", A_STAT, 32'h0000_04A4);
        check("clr1_irq", 256'(irq), 256'(0));
        wb_wr("qstart1", A_CTRL, 32'h3, 4'hF);
        wb_wr("qstart2", A_CTRL, 32'h3, 4'hF);
        wb_rd_chk("q_pend_status", A_STAT, 32'h0000_048D);
        wb_wr("qstart3", A_CTRL, 32'h3, 4'hF);
        wb_rd_chk("q_ovr_status", A_STAT, 32'h0000_049D);
        core_run("q1", '0, '1, 1'b0, 8'd7);
        check("q_second_offer", 256'(cw_valid), 256'(1));
        wb_rd_chk("q1_status", A_STAT, 32'h0000_07B3);
        core_run("q2", exp_cw, exp_cw, 1'b1, 8'd2);
        wb_rd_chk("q2_status", A_STAT, 32'h0000_02B6);
        check("q2_irq", 256'(irq), 256'(1));
        wb_rd_chk("q2_out0", cw_out(0), 32'hA5A5_0000);
        wb_wr("clr2", A_CTRL, 32'h6, 4'hF);
        wb_rd_chk("clr2_status", A_STAT, 32'h0000_02A4);
        check("clr2_irq", 256'(irq), 256'(0));

        // Serial writes into fill bank 1
        ser_bit(16'd207, 1'b1);
        wb_rd_chk("ser207", cw_in(6), 32'h0000_8000);
        ser_bit(16'd208, 1'b1);
        wb_rd_chk("ser208_ignored", cw_in(6), 32'h0000_8000);
        wb_wr_bit("wb_ser_same", cw_in(0), 32'h0000_00F0, 16'd4, 1'b0);
        wb_rd_chk("wb_ser_override", cw_in(0), 32'h0000_00E0);

        // START and serial write together: the bit lands in the bank being offered
        wb_wr_bit("start_ser", A_CTRL, 32'h3, 16'd0, 1'b1);
        @(negedge clk);
        check("start_ser_valid", 256'(cw_valid), 256'(1));
        check("start_ser_w0", 256'(cw_data[31:0]), 256'(32'h0000_00E1));
        check("start_ser_w6", 256'(cw_data[207:192]), 256'(16'h8000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
